// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a loadable pattern register,
// an overlapping/non-overlapping match mode and an optional saturating
// match counter.
// Build option: define SEQDET_COUNT_EN to implement the match counter and
// count_clr. Without it, match_cnt is tied to 0 and count_clr is ignored.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(3'b111),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             count_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              detect_q, detect_d;
    logic              match;

    // Pattern/history/fill state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q    <= PATTERN;
            hist_q   <= '0;
            fill_q   <= '0;
            detect_q <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            detect_q <= detect_d;
        end
    end

    // Next-state: pattern load beats sampling; a match compares post-shift history
    always_comb begin
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        detect_d = 1'b0;
        match    = 1'b0;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = {hist_q[PAT_W-2:0], in};
            fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
            if ((fill_d == FILL_FULL) && (hist_d == pat_q)) begin
                match    = 1'b1;
                detect_d = 1'b1;
                // Non-overlapping mode: next match needs a full fresh window
                if (!overlap) begin
                    fill_d = '0;
                end
            end
        end
    end

    assign detect = detect_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Match counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clear wins over a same-cycle match; increment saturates at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_inputs;

    // No counter in this build: the clear input and match strobe go nowhere
    assign unused_cnt_inputs = count_clr ^ match;
    assign match_cnt         = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a queue-based window model predicts detect and both counts.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       din;
    logic       in_valid;
    logic       overlap;
    logic       pat_load;
    logic [2:0] pat_in;
    logic       count_clr;
    logic       detect_a, detect_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         win[$];
    logic [2:0] m_pat;
    int         m_cnt8;
    int         m_cnt2;
    logic       m_det;

    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .detect(detect_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .detect(detect_b), .match_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    // Model: the window holds the most recent valid bits since the last
    // reset, pattern load or non-overlapping match; oldest bit first.
    task automatic model(input logic r, input logic l, input logic [2:0] p,
                         input logic v, input logic b, input logic o, input logic c);
        logic [2:0] w;
        m_det = 1'b0;
        if (r) begin
            win.delete();
            m_pat  = 3'b111;
            m_cnt8 = 0;
            m_cnt2 = 0;
            return;
        end
        if (l) begin
            m_pat = p;
            win.delete();
        end else if (v) begin
            win.push_back(b);
            if (win.size() > 3) void'(win.pop_front());
            if (win.size() == 3) begin
                w = {win[0], win[1], win[2]};
                if (w == m_pat) begin
                    m_det = 1'b1;
                    if (!o) win.delete();
                end
            end
        end
        if (c) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (m_det) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
    endtask

    // Drive one cycle, advance the model, then sample just after the edge
    task automatic cycle(input logic r, input logic l, input logic [2:0] p,
                         input logic v, input logic b, input logic o, input logic c);
        rst = r; pat_load = l; pat_in = p; in_valid = v; din = b; overlap = o; count_clr = c;
        model(r, l, p, v, b, o, c);
        @(posedge clk);
        #1;
        check("detect_a", int'(detect_a), int'(m_det));
        check("detect_b", int'(detect_b), int'(m_det));
`ifdef SEQDET_COUNT_EN
        check("cnt_a", int'(cnt_a), m_cnt8);
        check("cnt_b", int'(cnt_b), m_cnt2);
`else
        check("cnt_a", int'(cnt_a), 0);
        check("cnt_b", int'(cnt_b), 0);
`endif
    endtask

    task automatic vbit(input logic b, input logic o);
        cycle(1'b0, 1'b0, 3'b000, 1'b1, b, o, 1'b0);
    endtask

    task automatic gap(input logic b, input logic o);
        cycle(1'b0, 1'b0, 3'b000, 1'b0, b, o, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic r, l, v, b, o, c;
        logic [2:0] p;

        // Reset state
        do_reset();
        do_reset();

        // Three ones, overlapping: single detect after third bit
        vbit(1'b1, 1'b1); vbit(1'b1, 1'b1); vbit(1'b1, 1'b1);
        gap(1'b0, 1'b1);

        // Five ones, overlapping then non-overlapping
        do_reset();
        for (int i = 0; i < 5; i++) vbit(1'b1, 1'b1);
        gap(1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) vbit(1'b1, 1'b0);
        gap(1'b0, 1'b0);

        // Invalid gaps between ones
        do_reset();
        vbit(1'b1, 1'b1);
        gap(1'b1, 1'b1); gap(1'b1, 1'b1);
        vbit(1'b1, 1'b1); vbit(1'b1, 1'b1);
        gap(1'b1, 1'b1);

        // Pattern load discards history; then 1,0,1,0,1 with pattern 101
        do_reset();
        vbit(1'b1, 1'b1); vbit(1'b1, 1'b1);
        cycle(1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0);
        vbit(1'b1, 1'b1); vbit(1'b0, 1'b1); vbit(1'b1, 1'b1);
        vbit(1'b0, 1'b1); vbit(1'b1, 1'b1);
        gap(1'b0, 1'b1);

        // Saturation of the narrow counter, then clear on a coincident match
        do_reset();
        for (int i = 0; i < 7; i++) vbit(1'b1, 1'b1);
        cycle(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1);
        gap(1'b0, 1'b1);

        // Reset mid-sequence discards partial history
        vbit(1'b1, 1'b1); vbit(1'b1, 1'b1);
        do_reset();
        vbit(1'b1, 1'b1);
        gap(1'b0, 1'b1);

        // Mode change between samples leaves current window intact
        vbit(1'b1, 1'b1); vbit(1'b1, 1'b0); vbit(1'b1, 1'b1);

        // Randomized traffic
        o = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom % 120) == 0;
            l = ($urandom % 30) == 0;
            p = 3'($urandom);
            v = ($urandom % 4) != 0;
            b = ($urandom % 3) != 0;
            if (($urandom % 10) == 0) o = ~o;
            c = ($urandom % 40) == 0;
            cycle(r, l, p, v, b, o, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 3, giving the pattern length in bits (2..16).
REQ-002 The block SHALL have parameter PATTERN, default 3'b111 (PAT_W bits), giving the reset value of the pattern register.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-004 The block SHALL have port clk  input  1  as the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  as the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port in  input  1  as the serial data bit.
REQ-007 The block SHALL have port in_valid  input  1  to qualify in; when low, in is ignored.
REQ-008 The block SHALL have port overlap  input  1  to select mode: 1 = overlapping matches, 0 = non-overlapping.
REQ-009 The block SHALL have port pat_load  input  1  to load pat_in into the pattern register.
REQ-010 The block SHALL have port pat_in  input  PAT_W  as the new pattern, MSB being the oldest bit.
REQ-011 The block SHALL have port count_clr  input  1  to clear the match counter.
REQ-012 The block SHALL have port detect  output  1  as a registered one-cycle match pulse.
REQ-013 The block SHALL have port match_cnt  output  CNT_W  as a saturating count of matches.

Function
REQ-014 The block SHALL keep a history register hist (PAT_W bits) and a fill counter fill (0..PAT_W, saturating); on a valid sample hist shifts left and in enters at the LSB.
REQ-015 A match SHALL occur on a valid sample when the post-update fill equals PAT_W and the post-update hist equals pat_reg.
REQ-016 detect SHALL be high for exactly the one cycle following the edge that sampled the completing bit, and low otherwise (latency 1 clock).
REQ-017 With overlap=1, hist and fill SHALL be kept after a match, so consecutive overlapping windows each produce detect.
REQ-018 With overlap=0, fill SHALL be cleared to 0 on a match, so the next match needs PAT_W fresh valid bits.
REQ-019 A change of overlap SHALL take effect from the next valid sample; it SHALL NOT alter the current hist or fill.
REQ-020 On a cycle with in_valid=0, hist and fill SHALL hold, and detect SHALL be 0 the following cycle.
REQ-021 On pat_load=1, the block SHALL set pat_reg to pat_in, clear hist and fill to 0, and drive detect 0; in_valid is ignored that cycle.
REQ-022 Priority SHALL be rst > pat_load > in_valid sample.
REQ-023 match_cnt SHALL increment by 1 per match and saturate at all-ones (no wrap).
REQ-024 When count_clr=1, match_cnt SHALL become 0; if a match occurs in the same cycle, the clear wins and that match is not counted (detect still pulses).

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set pat_reg=PATTERN, hist=0, fill=0, detect=0, and match_cnt=0.
REQ-026 A reset mid-sequence SHALL discard all partial history; bits sampled before reset never contribute to a match.

Configuration
REQ-027 With SEQDET_COUNT_EN defined, the match counter and count_clr behaviour SHALL be implemented per REQ-023/024.
REQ-028 Without SEQDET_COUNT_EN, the block SHALL implement no counter registers, drive match_cnt constant 0, and ignore count_clr; all detect behaviour is unchanged.

Verification (PAT_W=3, PATTERN=3'b111, CNT_W=8, SEQDET_COUNT_EN defined unless noted)
REQ-029 Reset, then overlap=1 with valid bits 1,1,1 -> detect high exactly one cycle after the 3rd sample; match_cnt=1.
REQ-030 Valid bits 1,1,1,1,1 -> overlap=1 gives detect after bits 3, 4 and 5 with match_cnt=3; overlap=0 gives detect after bit 3 only with match_cnt=1.
REQ-031 Bits 1, (in_valid=0 for 2 cycles), 1, 1 -> single detect after the 3rd valid bit; no detect during gaps.
REQ-032 pat_load with pat_in=3'b101 after bits 1,1, then overlap=1 with bits 1,0,1,0,1 -> detect after the 3rd and 5th bits only.
REQ-033 CNT_W=2, 5 matches -> match_cnt=3 (saturated); count_clr in the same cycle as a 6th match -> match_cnt=0, detect=1.
REQ-034 Bits 1,1, rst, then bit 1 -> no detect; without SEQDET_COUNT_EN scenario REQ-029 -> detect identical, match_cnt=0.
